// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared default constants and the word type for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REGFILE_WIDTH = 10;
    localparam int REGFILE_DEPTH = 8;

    typedef logic [REGFILE_WIDTH-1:0] regfile_word_t;

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w_decoder_onehot.sv
`default_nettype none
// ============================================================================
// Module      : decoder_onehot
// Description : Enable-gated binary to one-hot decoder (write-enable generator).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_onehot #(
    parameter  int N  = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_en,
    input  logic [SW-1:0] i_sel,
    output logic [N-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : 1-write / 2-registered-read register file with read valid
//               strobes. Define REGFILE_BYPASS_EN for write-first forwarding;
//               otherwise reads return the pre-write contents.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = REGFILE_WIDTH,
    parameter  int DEPTH    = REGFILE_DEPTH,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             CLKb,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             ENW,
    input  logic [AW-1:0]    WRA,
    input  logic             ENR0,
    input  logic [AW-1:0]    RDA0,
    input  logic             ENR1,
    input  logic [AW-1:0]    RDA1,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             V0,
    output logic             V1
);

    localparam int c_nports = 2;

    logic [DEPTH-1:0] w_wen;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_enr [c_nports];
    logic [AW-1:0]    w_rda [c_nports];
    logic [WIDTH-1:0] w_rd  [c_nports];
    logic [WIDTH-1:0] r_q   [c_nports];
    logic             r_v   [c_nports];

    decoder_onehot #(
        .N (DEPTH)
    ) u_wdec (
        .i_en     (ENW),
        .i_sel    (WRA),
        .o_onehot (w_wen)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            // A hardwired zero register is held at zero and never written.
            localparam bit c_hardwire = (ZERO_REG != 0) && (gi == 0);

            always_ff @(posedge CLKb) begin
                if (RST) begin
                    r_mem[gi] <= '0;
                end else if (w_wen[gi] && !c_hardwire) begin
                    r_mem[gi] <= D;
                end
            end
        end
    endgenerate

    assign w_enr[0] = ENR0;
    assign w_rda[0] = RDA0;
    assign w_enr[1] = ENR1;
    assign w_rda[1] = RDA1;

    generate
        for (gi = 0; gi < c_nports; gi++) begin : g_port
            always_comb begin
                w_rd[gi] = r_mem[w_rda[gi]];
`ifdef REGFILE_BYPASS_EN
                if (ENW && (WRA == w_rda[gi])) begin
                    w_rd[gi] = D;
                end
`endif
                // Applied last so forwarding can never leak into register 0.
                if ((ZERO_REG != 0) && (w_rda[gi] == '0)) begin
                    w_rd[gi] = '0;
                end
            end

            always_ff @(posedge CLKb) begin
                if (RST) begin
                    r_q[gi] <= '0;
                    r_v[gi] <= 1'b0;
                end else begin
                    r_v[gi] <= w_enr[gi];
                    if (w_enr[gi]) begin
                        r_q[gi] <= w_rd[gi];
                    end
                end
            end
        end
    endgenerate

    assign Q0 = r_q[0];
    assign Q1 = r_q[1];
    assign V0 = r_v[0];
    assign V1 = r_v[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Directed self-checking bench for regfile_2r1w (default,
//               ZERO_REG=1 and 16x16 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // default instance
    logic       a_rst, a_enw, a_enr0, a_enr1, a_v0, a_v1;
    logic [9:0] a_d, a_q0, a_q1;
    logic [2:0] a_wra, a_rda0, a_rda1;
    // ZERO_REG instance
    logic       z_rst, z_enw, z_enr0, z_enr1, z_v0, z_v1;
    logic [9:0] z_d, z_q0, z_q1;
    logic [2:0] z_wra, z_rda0, z_rda1;
    // 16x16 instance
    logic        p_rst, p_enw, p_enr0, p_enr1, p_v0, p_v1;
    logic [15:0] p_d, p_q0, p_q1;
    logic [3:0]  p_wra, p_rda0, p_rda1;

    regfile_2r1w u_a (
        .CLKb(clk), .RST(a_rst), .D(a_d), .ENW(a_enw), .WRA(a_wra),
        .ENR0(a_enr0), .RDA0(a_rda0), .ENR1(a_enr1), .RDA1(a_rda1),
        .Q0(a_q0), .Q1(a_q1), .V0(a_v0), .V1(a_v1)
    );

    regfile_2r1w #(.ZERO_REG(1)) u_z (
        .CLKb(clk), .RST(z_rst), .D(z_d), .ENW(z_enw), .WRA(z_wra),
        .ENR0(z_enr0), .RDA0(z_rda0), .ENR1(z_enr1), .RDA1(z_rda1),
        .Q0(z_q0), .Q1(z_q1), .V0(z_v0), .V1(z_v1)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(16)) u_p (
        .CLKb(clk), .RST(p_rst), .D(p_d), .ENW(p_enw), .WRA(p_wra),
        .ENR0(p_enr0), .RDA0(p_rda0), .ENR1(p_enr1), .RDA1(p_rda1),
        .Q0(p_q0), .Q1(p_q1), .V0(p_v0), .V1(p_v1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [9:0]  hz_exp;
    logic [15:0] pat [16];

    initial begin
        a_rst = 1'b1; a_d = '0; a_enw = 1'b0; a_wra = '0;
        a_enr0 = 1'b1; a_rda0 = '0; a_enr1 = 1'b1; a_rda1 = '0;
        z_rst = 1'b1; z_d = '0; z_enw = 1'b0; z_wra = '0;
        z_enr0 = 1'b0; z_rda0 = '0; z_enr1 = 1'b0; z_rda1 = '0;
        p_rst = 1'b1; p_d = '0; p_enw = 1'b0; p_wra = '0;
        p_enr0 = 1'b0; p_rda0 = '0; p_enr1 = 1'b0; p_rda1 = '0;

        // ---------------- reset ----------------
        tick;
        chk("rst_q0", 32'(a_q0), 32'h0);
        chk("rst_q1", 32'(a_q1), 32'h0);
        chk("rst_v0", 32'(a_v0), 32'h0);
        chk("rst_v1", 32'(a_v1), 32'h0);
        a_rst = 1'b0; z_rst = 1'b0; p_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a_enr0 = 1'b1; a_rda0 = 3'(i);
            a_enr1 = 1'b1; a_rda1 = 3'(7 - i);
            tick;
            chk($sformatf("rstread_q0_%0d", i), 32'(a_q0), 32'h0);
            chk($sformatf("rstread_q1_%0d", i), 32'(a_q1), 32'h0);
            chk($sformatf("rstread_v0_%0d", i), 32'(a_v0), 32'h1);
            chk($sformatf("rstread_v1_%0d", i), 32'(a_v1), 32'h1);
        end

        // ---------------- write then read ----------------
        a_enr0 = 1'b0; a_enr1 = 1'b0;
        a_enw = 1'b1; a_wra = 3'd3; a_d = 10'h2A5;
        tick;
        chk("idle_v0", 32'(a_v0), 32'h0);
        a_enw = 1'b0;
        a_enr0 = 1'b1; a_rda0 = 3'd3; a_enr1 = 1'b1; a_rda1 = 3'd3;
        tick;
        chk("wr_q0", 32'(a_q0), 32'h2A5);
        chk("wr_q1_same_addr", 32'(a_q1), 32'h2A5);
        chk("wr_v0", 32'(a_v0), 32'h1);
        a_rda0 = 3'd2; a_enr1 = 1'b0; a_rda1 = 3'd4;
        tick;
        chk("rd2_q0", 32'(a_q0), 32'h0);
        chk("rd2_v0", 32'(a_v0), 32'h1);
        chk("hold_v1", 32'(a_v1), 32'h0);
        chk("hold_q1", 32'(a_q1), 32'h2A5);

        // ---------------- same-cycle hazard ----------------
        a_enr0 = 1'b0;
        a_enw = 1'b1; a_wra = 3'd5; a_d = 10'h0AA;
        tick;
        a_d = 10'h155; a_enr1 = 1'b1; a_rda1 = 3'd5;
        tick;
`ifdef REGFILE_BYPASS_EN
        hz_exp = 10'h155;
`else
        hz_exp = 10'h0AA;
`endif
        chk("hazard_q1", 32'(a_q1), 32'(hz_exp));
        chk("hazard_v1", 32'(a_v1), 32'h1);
        chk("hold_v0", 32'(a_v0), 32'h0);
        chk("hold_q0", 32'(a_q0), 32'h0);
        a_enw = 1'b0;
        tick;
        chk("hazard_after_q1", 32'(a_q1), 32'h155);

        // ---------------- mid-stream reset ----------------
        a_enr1 = 1'b0;
        a_enw = 1'b1; a_wra = 3'd2; a_d = 10'h111;
        tick;
        a_enw = 1'b0; a_enr0 = 1'b1; a_rda0 = 3'd2;
        tick;
        chk("stream_q0", 32'(a_q0), 32'h111);
        tick;
        chk("stream_q0_b2b", 32'(a_q0), 32'h111);
        a_rst = 1'b1; a_enw = 1'b1; a_wra = 3'd2; a_d = 10'h3C3;
        tick;
        chk("midrst_q0", 32'(a_q0), 32'h0);
        chk("midrst_v0", 32'(a_v0), 32'h0);
        a_rst = 1'b0; a_enw = 1'b0;
        a_enr1 = 1'b1; a_rda1 = 3'd3;
        tick;
        chk("postrst_q0", 32'(a_q0), 32'h0);
        chk("postrst_v0", 32'(a_v0), 32'h1);
        chk("postrst_q1_r3", 32'(a_q1), 32'h0);

        // ---------------- ZERO_REG instance ----------------
        z_enw = 1'b1; z_wra = 3'd0; z_d = 10'h3FF;
        tick;
        z_wra = 3'd1; z_d = 10'h1AB;
        tick;
        z_enw = 1'b0;
        z_enr0 = 1'b1; z_rda0 = 3'd0; z_enr1 = 1'b1; z_rda1 = 3'd0;
        tick;
        chk("zr_q0_a0", 32'(z_q0), 32'h0);
        chk("zr_q1_a0", 32'(z_q1), 32'h0);
        z_rda0 = 3'd1; z_rda1 = 3'd1;
        tick;
        chk("zr_q0_a1", 32'(z_q0), 32'h1AB);
        chk("zr_q1_a1", 32'(z_q1), 32'h1AB);
        // write to 0 alongside read of 0: always zero in either build
        z_enw = 1'b1; z_wra = 3'd0; z_d = 10'h2DD; z_rda0 = 3'd0; z_rda1 = 3'd1;
        tick;
        chk("zr_fwd_q0_a0", 32'(z_q0), 32'h0);
        chk("zr_q1_a1_again", 32'(z_q1), 32'h1AB);
        z_enw = 1'b0; z_enr0 = 1'b0; z_enr1 = 1'b0;

        // ---------------- 16x16 instance ----------------
        for (int i = 0; i < 16; i++) begin
            pat[i] = 16'h1357 + 16'(i) * 16'h0F0F;
        end
        for (int i = 0; i < 16; i++) begin
            p_enw = 1'b1; p_wra = 4'(i); p_d = pat[i];
            tick;
        end
        p_enw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            p_enr0 = 1'b1; p_rda0 = 4'(i);
            p_enr1 = 1'b1; p_rda1 = 4'(15 - i);
            tick;
            chk($sformatf("p_q0_%0d", i), 32'(p_q0), 32'(pat[i]));
            chk($sformatf("p_q1_%0d", 15 - i), 32'(p_q1), 32'(pat[15 - i]));
            chk($sformatf("p_v0_%0d", i), 32'(p_v0), 32'h1);
        end
        p_enr0 = 1'b0; p_enr1 = 1'b0;
        tick;
        chk("p_v1_idle", 32'(p_v1), 32'h0);
        chk("p_q1_hold", 32'(p_q1), 32'(pat[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file, successor to the fixed 10-bit × 8 tristate-output register file in the datapath. It provides one synchronous write port and two independent registered read ports with per-port valid strobes. Reads are driven muxed, not tristated. Width, depth and an optional hardwired-zero register are configurable. It sits between the instruction decoder, which supplies the addresses, and the ALU operand latches.

## Interface
Parameters:
- WIDTH, 10: data width in bits.
- DEPTH, 8: number of registers; power of two, ≥2.
- ZERO_REG, 0: if 1, register 0 reads as 0 and ignores writes.
- AW, $clog2(DEPTH): address width; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- CLKb  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- D  in  WIDTH  write data.
- ENW  in  1  write enable.
- WRA  in  AW  write address.
- ENR0  in  1  read port 0 enable.
- RDA0  in  AW  read port 0 address.
- ENR1  in  1  read port 1 enable.
- RDA1  in  AW  read port 1 address.
- Q0  out  WIDTH  registered read data, port 0.
- Q1  out  WIDTH  registered read data, port 1.
- V0  out  1  Q0 updated this cycle, i.e. ENR0 was high on the previous edge.
- V1  out  1  same as V0, for port 1.

## Operation
- Write: on an edge with ENW=1 and RST=0, reg[WRA] ← D. With ZERO_REG=1 and WRA=0, the write is dropped.
- Read port k: on an edge with ENRk=1, Qk ← reg[RDAk] and Vk ← 1. With ENRk=0, Qk holds its previous value and Vk ← 0.
- Both ports may read the same address in the same cycle; both return identical data.
- With ZERO_REG=1, a read of address 0 always returns 0.
- Reset: when RST=1 on an edge, all registers, Q0, Q1, V0 and V1 are set to 0. RST overrides ENW and ENR0/ENR1 in that cycle.
- No X propagation: every register has a defined value from the first reset onward.

## Timing
- Write latency: data written at edge n is visible to a read sampled at edge n+1.
- Read latency: 1 cycle. Address at edge n gives Qk and Vk valid after edge n, stable until edge n+1.
- Read-during-write to the same address in the same cycle depends on configuration (see Configuration).
- Back-to-back reads with ENRk held high return a new value every cycle; throughput is 1 read per port per cycle.
- RST asserted mid-stream: the next outputs are Q=0 and V=0. The first valid read after deassertion appears one cycle after the first ENRk=1 edge.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If ENW=1, ENRk=1 and WRA==RDAk on the same edge, Qk ← D. The exception is ZERO_REG=1 with address 0, where Qk ← 0.
- Undefined: read-first. Qk ← the old reg[RDAk], and the new value is visible from the next read.
- Storage and latency are identical in both builds.

## Structure
- Package regfile_pkg holds:
  - default constants REGFILE_WIDTH=10 and REGFILE_DEPTH=8;
  - typedef regfile_word_t (logic [REGFILE_WIDTH-1:0]).
- Sub-module decoder_onehot (parameter N, enable input, one-hot output) generates the write enables from WRA and ENW. It is the parametrised generalisation of the existing 3-to-8 decoder.
- Read selection is a plain indexed mux per port; no decoder is needed on the read side.

## Test plan
- Reset: pulse RST for 1 cycle, then read all 8 addresses on both ports → Q0=Q1=0, V=1 one cycle after each ENR.
- Write/read: write 10'h2A5 to addr 3, next cycle ENR0 with RDA0=3 → Q0=10'h2A5 and V0=1 one cycle later. ENR1 idle → V1=0 and Q1 holds.
- Same-cycle hazard: write 10'h155 to addr 5 with ENR1 and RDA1=5 on the same edge (old value 10'h0AA) → Q1=10'h155 with REGFILE_BYPASS_EN, 10'h0AA without; the following read returns 10'h155 in both builds.
- ZERO_REG=1: write 10'h3FF to addr 0, read addr 0 on both ports → Q0=Q1=0. Addr 1 is unaffected.
- Mid-stream reset: continuous reads of addr 2 (10'h111), assert RST for 1 cycle together with ENW to addr 2 → next Q0=0, V0=0, reg2 reads 0 afterwards, and the write is lost.
- Parametric build: WIDTH=16, DEPTH=16. Write a distinct pattern to every register, then read both ports with different addresses each cycle → all 16 values are correct at 1 read per port per cycle.
